// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit that feeds the HI/LO register.
// It computes 64-bit {HI,LO} write data for the MULT/MADD/MSUB family
// (one-cycle multiply), DIV/DIVU (restoring divide) and MTHI/MTLO.
// While a multi-cycle operation is in flight it raises stallreq.
module mul_div_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  input  logic [63:0] hilo_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        hilo_wen,
  output logic [63:0] hilo_wdata,
  output logic        stallreq,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [31:0]   a_q, a_d;        // raw opr1 (multiplicand / div-by-zero HI)
  logic [31:0]   b_q, b_d;        // raw opr2 (multiplier)
  logic [31:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [31:0]   rem_q, rem_d;    // partial remainder
  logic [31:0]   quo_q, quo_d;    // dividend shifting out / quotient shifting in
  logic [63:0]   prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;

  // Datapath helpers shared by the next-state logic.
  logic        mul_signed;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] shifted, trial;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] div_result;
  logic        div_signed;

  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign ext_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product    = ext_a * ext_b;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor; a clear borrow bit means the subtract stands.
  assign shifted    = {rem_q, quo_q[31]};
  assign trial      = shifted - {1'b0, dvs_q};

  assign quo_fix    = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign rem_fix    = rneg_q ? (32'd0 - rem_q) : rem_q;
  assign div_result = dz_q ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

  assign div_signed = (mdu_op == OP_DIV);
  assign busy       = (state_q != S_IDLE);

  // State and operand registers; reset clears everything so an aborted
  // operation leaves no stale result behind.
  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together from the values sampled at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state, datapath update and output decode.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    hilo_wen   = 1'b0;
    hilo_wdata = 64'd0;
    stallreq   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        case (mdu_op)
          OP_MTHI: begin
            hilo_wen = !stall;
            if (!stall) hilo_wdata = {opr1, hilo_rdata[31:0]};
          end
          OP_MTLO: begin
            hilo_wen = !stall;
            if (!stall) hilo_wdata = {hilo_rdata[63:32], opr1};
          end
          OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            op_d     = op_e'(mdu_op);
            a_d      = opr1;
            b_d      = opr2;
            stallreq = 1'b1;
            state_d  = S_MUL;
          end
          OP_DIV, OP_DIVU: begin
            op_d     = op_e'(mdu_op);
            a_d      = opr1;
            b_d      = opr2;
            quo_d    = (div_signed && opr1[31]) ? (32'd0 - opr1) : opr1;
            dvs_d    = (div_signed && opr2[31]) ? (32'd0 - opr2) : opr2;
            rem_d    = 32'd0;
            qneg_d   = div_signed && (opr1[31] ^ opr2[31]);
            rneg_d   = div_signed && opr1[31];
            dz_d     = (opr2 == 32'd0);
            cnt_d    = '0;
            stallreq = 1'b1;
            state_d  = S_DIV;
          end
          default: ;
        endcase
      end

      S_MUL: begin
        prod_d   = product;
        stallreq = 1'b1;
        state_d  = S_DONE;
      end

      S_DIV: begin
        stallreq = 1'b1;
        if (dz_q) begin
          state_d = S_DONE;
        end else begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        if (!stall) begin
          hilo_wen = 1'b1;
          unique case (op_q)
            OP_MADD, OP_MADDU: hilo_wdata = hilo_rdata + prod_q;
            OP_MSUB, OP_MSUBU: hilo_wdata = hilo_rdata - prod_q;
            OP_DIV, OP_DIVU:   hilo_wdata = div_result;
            default:           hilo_wdata = prod_q;
          endcase
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush cancels whatever is in flight and suppresses any write.
    if (flush) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      hilo_wen   = 1'b0;
      hilo_wdata = 64'd0;
      stallreq   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit. Inputs change on
// the falling edge and outputs are sampled 1 time unit later.
module tb_mul_div_unit;

  localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                         DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd7,
                         MADDU = 4'd8, MSUB = 4'd9, MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mdu_op;
  logic [31:0] opr1, opr2;
  logic [63:0] hilo_rdata;
  logic        stall, flush;
  logic        hilo_wen;
  logic [63:0] hilo_wdata;
  logic        stallreq, busy;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mdu_op     (mdu_op),
    .opr1       (opr1),
    .opr2       (opr2),
    .hilo_rdata (hilo_rdata),
    .stall      (stall),
    .flush      (flush),
    .hilo_wen   (hilo_wen),
    .hilo_wdata (hilo_wdata),
    .stallreq   (stallreq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation and hold it until stallreq drops, as the pipeline
  // would; then check stall length, the write and the return to idle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] hr,
                       input int exp_stalls, input logic [63:0] exp_data);
    int  n;
    bit  done;
    bit  early_write;
    @(negedge clk);
    mdu_op = op; opr1 = a; opr2 = b; hilo_rdata = hr; stall = 1'b0; flush = 1'b0;
    n = 0; done = 1'b0; early_write = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      #1;
      if (stallreq) begin
        n++;
        if (hilo_wen || hilo_wdata != 64'd0) early_write = 1'b1;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_stalls"}, 64'(n), 64'(exp_stalls));
    check({tag, "_quiet"}, 64'(early_write), 64'd0);
    check({tag, "_wen"}, 64'(hilo_wen), 64'd1);
    check({tag, "_data"}, hilo_wdata, exp_data);
    @(negedge clk);
    mdu_op = NOP;
    #1;
    check({tag, "_idle"}, {62'd0, busy, hilo_wen}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [63:0] pulse_data;
    bit saw_wen;

    rst = 1'b1; mdu_op = NOP; opr1 = '0; opr2 = '0; hilo_rdata = '0;
    stall = 1'b0; flush = 1'b0;
    #12;
    check("reset_outs", {hilo_wdata[62:0], hilo_wen}, 64'd0);
    check("reset_ctl", {62'd0, stallreq, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply family
    do_op("mult",  MULT,  32'hFFFF_FFFE, 32'd3, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 64'd0, 2, 64'h0000_0002_FFFF_FFFA);
    do_op("madd",  MADD,  32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, 2, 64'h0000_0001_0000_0000);
    do_op("msubu", MSUBU, 32'd1, 32'd1, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("msub",  MSUB,  32'hFFFF_FFFE, 32'd3, 64'd10, 2, 64'd16);

    // Divide family
    do_op("div_m7_2",  DIV,  32'hFFFF_FFF9, 32'd2, 64'd0, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_100_7", DIVU, 32'd100, 32'd7, 64'd0, 33, 64'h0000_0002_0000_000E);
    do_op("div_7_m2",  DIV,  32'd7, 32'hFFFF_FFFE, 64'd0, 33, 64'h0000_0001_FFFF_FFFD);
    do_op("divu_z",    DIVU, 32'h0000_1234, 32'd0, 64'd0, 2, 64'h0000_1234_FFFF_FFFF);
    do_op("div_z_neg", DIV,  32'hFFFF_FFFB, 32'd0, 64'd0, 2, 64'hFFFF_FFFB_FFFF_FFFF);
    do_op("div_ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 33, 64'h0000_0000_8000_0000);

    // MTHI / MTLO are same-cycle writes
    @(negedge clk);
    mdu_op = MTHI; opr1 = 32'hA5A5_A5A5; hilo_rdata = 64'h1111_2222_3333_4444;
    #1;
    check("mthi_wen", 64'(hilo_wen), 64'd1);
    check("mthi_data", hilo_wdata, 64'hA5A5_A5A5_3333_4444);
    check("mthi_stallreq", 64'(stallreq), 64'd0);
    stall = 1'b1;
    #1;
    check("mthi_stalled", {hilo_wdata[62:0], hilo_wen}, 64'd0);
    stall = 1'b0;
    mdu_op = MTLO;
    #1;
    check("mtlo_data", hilo_wdata, 64'h1111_2222_A5A5_A5A5);
    @(negedge clk);
    mdu_op = NOP;
    #1;
    check("mtlo_nostate", 64'(busy), 64'd0);

    // Flush in the middle of a divide
    @(negedge clk);
    mdu_op = DIV; opr1 = 32'd1000; opr2 = 32'd3;
    saw_wen = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      #1;
      if (hilo_wen) saw_wen = 1'b1;
    end
    flush = 1'b1;
    #1;
    check("flush_comb", {62'd0, stallreq, hilo_wen}, 64'd0);
    check("flush_nowrite", 64'(saw_wen), 64'd0);
    @(negedge clk);
    flush = 1'b0; mdu_op = NOP;
    #1;
    check("flush_idle", {62'd0, busy, stallreq}, 64'd0);
    do_op("mult_after_flush", MULT, 32'd3, 32'd5, 64'd0, 2, 64'd15);

    // Stall held in DONE: exactly one write after release
    @(negedge clk);
    mdu_op = MULTU; opr1 = 32'd6; opr2 = 32'd7;
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    pulses = 0; pulse_data = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (hilo_wen) pulses++;
      @(negedge clk);
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (hilo_wen) begin pulses++; pulse_data = hilo_wdata; end
      @(negedge clk);
      mdu_op = NOP;
    end
    check("done_stall_pulses", 64'(pulses), 64'd1);
    check("done_stall_data", pulse_data, 64'd42);

    // Asynchronous reset mid-divide
    @(negedge clk);
    mdu_op = DIVU; opr1 = 32'd50; opr2 = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; mdu_op = NOP;
    #1;
    check("rst_abort", {62'd0, busy, hilo_wen}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after", {61'd0, busy, stallreq, hilo_wen}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
